// File: rtl/multi_byte.sv
// Byte-to-word assembler: packs 1..BYTES incoming bytes into a right-aligned word,
// with per-word length, selectable byte order and a one-entry ack-held output slot.
module multi_byte #(
  parameter int BYTES      = 4,
  parameter bit BIG_ENDIAN = 1'b1,
  parameter int LW         = $clog2(BYTES) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           current_byte,
  input  logic                 ie,
  input  logic [LW-1:0]        length,
  input  logic                 abort,
  input  logic                 ack,
  output logic                 ready,
  output logic [8*BYTES-1:0]   value,
  output logic [LW-1:0]        value_len,
  output logic                 oe,
  output logic                 overrun
);

  localparam int W = 8 * BYTES;
  localparam logic [LW-1:0] MAX_LEN = LW'(BYTES);

  typedef enum logic {
    IDLE,
    COLLECT
  } phase_e;

  logic [LW-1:0] count_q, count_d;
  logic [LW-1:0] target_q, target_d;
  logic [W-1:0]  shift_q, shift_d;
  logic [W-1:0]  value_q, value_d;
  logic [LW-1:0] value_len_q, value_len_d;
  logic          oe_q, oe_d;
  logic          overrun_q, overrun_d;

  phase_e        phase;
  logic [LW-1:0] len_clamped;
  logic [LW-1:0] eff_target;
  logic          completes;
  logic          take;
  logic          word_done;
  logic [W-1:0]  base;
  logic [W-1:0]  packed_word;

  // Handshake decode: the completing byte is the only one that needs a free slot.
  always_comb begin
    phase       = (count_q == '0) ? IDLE : COLLECT;
    len_clamped = (length == '0 || length > MAX_LEN) ? MAX_LEN : length;
    eff_target  = (phase == IDLE) ? len_clamped : target_q;
    completes   = (count_q + LW'(1)) == eff_target;
    ready       = !(oe_q && !ack && completes);
    take        = ie && !abort && ready;
    word_done   = take && completes;
  end

  // A new word starts from an all-zero image so unused upper bytes stay zero.
  always_comb begin
    base = (phase == IDLE) ? '0 : shift_q;
    if (BIG_ENDIAN) begin
      packed_word = {base[W-9:0], current_byte};
    end else begin
      packed_word = base;
      for (int k = 0; k < BYTES; k++) begin
        if (count_q == LW'(k)) packed_word[8*k +: 8] = current_byte;
      end
    end
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    count_d     = count_q;
    target_d    = target_q;
    shift_d     = shift_q;
    value_d     = value_q;
    value_len_d = value_len_q;
    oe_d        = oe_q;
    overrun_d   = overrun_q;

    if (oe_q && ack) oe_d = 1'b0;

    if (abort) begin
      count_d  = '0;
      target_d = '0;
      shift_d  = '0;
    end else if (ie && !ready) begin
      overrun_d = 1'b1;
    end else if (take) begin
      if (word_done) begin
        count_d     = '0;
        target_d    = '0;
        shift_d     = '0;
        value_d     = packed_word;
        value_len_d = eff_target;
        oe_d        = 1'b1;
      end else begin
        count_d  = count_q + LW'(1);
        target_d = eff_target;
        shift_d  = packed_word;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q     <= '0;
      target_q    <= '0;
      shift_q     <= '0;
      value_q     <= '0;
      value_len_q <= '0;
      oe_q        <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      count_q     <= count_d;
      target_q    <= target_d;
      shift_q     <= shift_d;
      value_q     <= value_d;
      value_len_q <= value_len_d;
      oe_q        <= oe_d;
      overrun_q   <= overrun_d;
    end
  end

  assign value     = value_q;
  assign value_len = value_len_q;
  assign oe        = oe_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_multi_byte.sv
// Self-checking bench for multi_byte: big- and little-endian instances share stimulus
// and are compared against a queue-based word model plus directed vectors.
module tb_multi_byte;

  localparam int BYTES = 4;
  localparam int LW    = $clog2(BYTES) + 1;
  localparam int W     = 8 * BYTES;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    current_byte;
  logic          ie, abort, ack;
  logic [LW-1:0] length;

  logic          ready_be, oe_be, overrun_be;
  logic [W-1:0]  value_be;
  logic [LW-1:0] value_len_be;
  logic          ready_le, oe_le, overrun_le;
  logic [W-1:0]  value_le;
  logic [LW-1:0] value_len_le;

  always #5 clk = ~clk;

  multi_byte #(.BYTES(BYTES), .BIG_ENDIAN(1'b1)) u_be (
    .clk(clk), .reset(reset), .current_byte(current_byte), .ie(ie), .length(length),
    .abort(abort), .ack(ack), .ready(ready_be), .value(value_be), .value_len(value_len_be),
    .oe(oe_be), .overrun(overrun_be)
  );

  multi_byte #(.BYTES(BYTES), .BIG_ENDIAN(1'b0)) u_le (
    .clk(clk), .reset(reset), .current_byte(current_byte), .ie(ie), .length(length),
    .abort(abort), .ack(ack), .ready(ready_le), .value(value_le), .value_len(value_len_le),
    .oe(oe_le), .overrun(overrun_le)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Reference model: bytes of the word in progress kept as a queue; words built arithmetically.
  logic [7:0]  m_q[$];
  int          m_tgt;
  bit          m_oe, m_ovr;
  int          m_len;
  logic [31:0] m_be, m_le;

  function automatic int clamp(input int l);
    return (l == 0 || l > BYTES) ? BYTES : l;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_tgt = 0;
    m_oe  = 1'b0;
    m_ovr = 1'b0;
    m_len = 0;
    m_be  = '0;
    m_le  = '0;
  endtask

  task automatic model_check_and_advance();
    int eff;
    bit exp_ready;
    bit done;
    eff       = (m_q.size() == 0) ? clamp(int'(length)) : m_tgt;
    exp_ready = !(m_oe && !ack && (m_q.size() + 1 == eff));
    check("model.ready_be", ready_be, exp_ready);
    check("model.ready_le", ready_le, exp_ready);
    check("model.oe_be", oe_be, m_oe);
    check("model.oe_le", oe_le, m_oe);
    check("model.value_be", value_be, m_be);
    check("model.value_le", value_le, m_le);
    check("model.len_be", value_len_be, m_len);
    check("model.len_le", value_len_le, m_len);
    check("model.overrun_be", overrun_be, m_ovr);
    check("model.overrun_le", overrun_le, m_ovr);

    done = 1'b0;
    if (abort) begin
      m_q.delete();
    end else if (ie && !exp_ready) begin
      m_ovr = 1'b1;
    end else if (ie) begin
      if (m_q.size() == 0) m_tgt = eff;
      m_q.push_back(current_byte);
      if (m_q.size() == m_tgt) begin
        m_be = '0;
        m_le = '0;
        foreach (m_q[k]) begin
          m_be = (m_be << 8) | 32'(m_q[k]);
          m_le = m_le | (32'(m_q[k]) << (8 * k));
        end
        m_len = m_tgt;
        m_oe  = 1'b1;
        done  = 1'b1;
        m_q.delete();
      end
    end
    if (!done && m_oe && ack) m_oe = 1'b0;
  endtask

  task automatic apply(input logic i, input logic [7:0] b, input logic [LW-1:0] l,
                       input logic ab, input logic a);
    ie           = i;
    current_byte = b;
    length       = l;
    abort        = ab;
    ack          = a;
  endtask

  task automatic finish_cycle();
    model_check_and_advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(input logic i, input logic [7:0] b, input logic [LW-1:0] l,
                      input logic ab, input logic a);
    apply(i, b, l, ab, a);
    #1;
    finish_cycle();
  endtask

  typedef struct {
    logic          ie;
    logic [7:0]    b;
    logic [LW-1:0] len;
    logic          ab;
    logic          ack;
    logic          ready;
    logic          oe;
    logic [31:0]   vbe;
    logic [31:0]   vle;
    logic [LW-1:0] vlen;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Outputs listed are those visible during the cycle the inputs are applied.
    tbl[0]  = '{1'b1, 8'h12, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'h0,        3'd0};
    tbl[1]  = '{1'b1, 8'h34, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'h0,        3'd0};
    tbl[2]  = '{1'b1, 8'h56, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'h0,        3'd0};
    tbl[3]  = '{1'b1, 8'h78, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'h0,        3'd0};
    tbl[4]  = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h12345678, 32'h78563412, 3'd4};
    tbl[5]  = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h12345678, 32'h78563412, 3'd4};
    tbl[6]  = '{1'b1, 8'hAA, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 32'h12345678, 32'h78563412, 3'd4};
    tbl[7]  = '{1'b1, 8'hBB, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 32'h12345678, 32'h78563412, 3'd4};
    tbl[8]  = '{1'b1, 8'hCC, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 32'h12345678, 32'h78563412, 3'd4};
    tbl[9]  = '{1'b0, 8'h00, 3'd1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00AABBCC, 32'h00CCBBAA, 3'd3};
    tbl[10] = '{1'b1, 8'h5A, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00AABBCC, 32'h00CCBBAA, 3'd3};
    tbl[11] = '{1'b0, 8'h00, 3'd1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000005A, 32'h0000005A, 3'd1};
    tbl[12] = '{1'b0, 8'h00, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000005A, 32'h0000005A, 3'd1};

    apply(1'b0, 8'h00, '0, 1'b0, 1'b0);
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst.oe", oe_be, 1'b0);
    check("rst.value", value_be, 32'h0);
    check("rst.value_len", value_len_be, 3'd0);
    check("rst.overrun", overrun_le, 1'b0);
    check("rst.ready", ready_be, 1'b1);
    reset = 1'b1;

    // Directed vectors: full-length big-endian word with ack tied high, then short words.
    for (int i = 0; i < 13; i++) begin
      apply(tbl[i].ie, tbl[i].b, tbl[i].len, tbl[i].ab, tbl[i].ack);
      #1;
      check($sformatf("tbl%0d.ready", i), ready_be, tbl[i].ready);
      check($sformatf("tbl%0d.oe", i), oe_le, tbl[i].oe);
      check($sformatf("tbl%0d.value_be", i), value_be, tbl[i].vbe);
      check($sformatf("tbl%0d.value_le", i), value_le, tbl[i].vle);
      check($sformatf("tbl%0d.len", i), value_len_be, tbl[i].vlen);
      finish_cycle();
    end

    // Abort mid-word, with a byte offered in the abort cycle.
    step(1'b1, 8'h11, 3'd4, 1'b0, 1'b1);
    step(1'b1, 8'h22, 3'd4, 1'b0, 1'b1);
    step(1'b1, 8'h99, 3'd4, 1'b1, 1'b1);
    step(1'b1, 8'h33, 3'd4, 1'b0, 1'b1);
    step(1'b1, 8'h44, 3'd4, 1'b0, 1'b1);
    step(1'b1, 8'h55, 3'd4, 1'b0, 1'b1);
    step(1'b1, 8'h66, 3'd4, 1'b0, 1'b1);
    apply(1'b0, 8'h00, 3'd4, 1'b0, 1'b1);
    #1;
    check("abort.oe", oe_be, 1'b1);
    check("abort.value_be", value_be, 32'h33445566);
    check("abort.value_le", value_le, 32'h66554433);
    check("abort.overrun", overrun_be, 1'b0);
    finish_cycle();

    // Backpressure: slot full, completing byte refused, earlier byte accepted.
    step(1'b1, 8'h01, 3'd2, 1'b0, 1'b0);
    step(1'b1, 8'h02, 3'd2, 1'b0, 1'b0);
    apply(1'b1, 8'h03, 3'd2, 1'b0, 1'b0);
    #1;
    check("bp.ready_first", ready_be, 1'b1);
    finish_cycle();
    apply(1'b1, 8'h04, 3'd2, 1'b0, 1'b0);
    #1;
    check("bp.ready_completing_be", ready_be, 1'b0);
    check("bp.ready_completing_le", ready_le, 1'b0);
    finish_cycle();
    apply(1'b0, 8'h00, 3'd2, 1'b0, 1'b0);
    #1;
    check("bp.overrun", overrun_be, 1'b1);
    check("bp.oe", oe_be, 1'b1);
    check("bp.value_be", value_be, 32'h00000102);
    check("bp.value_le", value_le, 32'h00000201);
    finish_cycle();
    step(1'b0, 8'h00, 3'd2, 1'b0, 1'b1);
    step(1'b0, 8'h00, 3'd2, 1'b1, 1'b0);

    // Completing byte coincident with ack: no gap in oe, value replaced.
    step(1'b1, 8'h01, 3'd2, 1'b0, 1'b0);
    step(1'b1, 8'h02, 3'd2, 1'b0, 1'b0);
    apply(1'b1, 8'h03, 3'd2, 1'b0, 1'b0);
    #1;
    check("swap.oe_a", oe_be, 1'b1);
    finish_cycle();
    apply(1'b1, 8'h04, 3'd2, 1'b0, 1'b1);
    #1;
    check("swap.ready", ready_be, 1'b1);
    check("swap.oe_b", oe_le, 1'b1);
    check("swap.value_old", value_be, 32'h00000102);
    finish_cycle();
    apply(1'b0, 8'h00, 3'd2, 1'b0, 1'b0);
    #1;
    check("swap.oe_c", oe_be, 1'b1);
    check("swap.value_be", value_be, 32'h00000304);
    check("swap.value_le", value_le, 32'h00000403);
    finish_cycle();
    step(1'b0, 8'h00, 3'd2, 1'b0, 1'b1);

    // Asynchronous reset while a word is held and another is half built.
    step(1'b1, 8'hA1, 3'd2, 1'b0, 1'b0);
    step(1'b1, 8'hA2, 3'd2, 1'b0, 1'b0);
    step(1'b1, 8'hB1, 3'd4, 1'b0, 1'b0);
    step(1'b1, 8'hB2, 3'd4, 1'b0, 1'b0);
    apply(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("arst.oe", oe_be, 1'b0);
    check("arst.value", value_be, 32'h0);
    check("arst.value_le", value_le, 32'h0);
    check("arst.overrun", overrun_be, 1'b0);
    check("arst.ready", ready_be, 1'b1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 8'hC1, 3'd4, 1'b0, 1'b1);
    step(1'b1, 8'hC2, 3'd4, 1'b0, 1'b1);
    step(1'b1, 8'hC3, 3'd4, 1'b0, 1'b1);
    step(1'b1, 8'hC4, 3'd4, 1'b0, 1'b1);
    apply(1'b0, 8'h00, 3'd4, 1'b0, 1'b1);
    #1;
    check("post_rst.value", value_be, 32'hC1C2C3C4);
    check("post_rst.len", value_len_le, 3'd4);
    finish_cycle();

    // Randomized traffic against the model.
    repeat (2000) begin
      step($urandom_range(0, 9) < 7, 8'($urandom), LW'($urandom_range(0, 7)),
           $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_byte.md
Name: multi_byte

Overview:
- Parametrised successor of the fixed 4-byte assembler: packs a stream of bytes into words of 1..BYTES bytes.
- Word length is selectable per word, byte order is selectable, and a one-entry output holding register gives ready/ack backpressure.
- Sits between the serial/command byte decoder and any consumer of multi-byte arguments (colours, coordinates, addresses).

Parameters:
- BYTES, 4, maximum bytes per word (2..8).
- BIG_ENDIAN, 1: 1 = first byte received ends up most significant; 0 = first byte lands in bits [7:0].
- LW, $clog2(BYTES)+1, width of length fields (derived, not overridden).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous active-low reset (0 = reset).
- current_byte  in  8  incoming byte.
- ie  in  1  current_byte valid this cycle.
- length  in  LW  bytes in the word being started; sampled with the first byte of each word.
- abort  in  1  discard any partially assembled word.
- ack  in  1  consumer takes value this cycle (effective only while oe=1).
- ready  out  1  byte accepted this cycle if ie=1.
- value  out  8*BYTES  assembled word, right-aligned, unused upper bytes zero.
- value_len  out  LW  number of valid bytes in value (1..BYTES).
- oe  out  1  value valid; held until acked.
- overrun  out  1  sticky: a byte was presented while ready=0.

Behaviour:
- Reset (async assert, sync release): count=0, target=0, shift regs=0, value=0, value_len=0, oe=0, overrun=0. ready reads 1 after reset.
- States:
  - IDLE (count=0): on ie&ready, latch target = length. Length 0 or length > BYTES is treated as BYTES. Store byte, count=1.
  - COLLECT (0<count<target): each ie&ready stores the next byte and count++.
  - The byte making count==target completes the word. Next cycle: value/value_len loaded, oe=1, count=0 (back to IDLE).
- target=1: first byte completes the word immediately. oe rises on the next edge (1-cycle latency, same as every word).
- Packing:
  - BIG_ENDIAN=1: shift left by 8 and insert at [7:0]; final value = bytes right-aligned, first byte highest.
  - BIG_ENDIAN=0: byte k (0-based) goes to bits [8k+7:8k].
  - In both modes, bits above 8*value_len are zero.
- Output slot: oe stays 1, and value/value_len stay stable, until ack=1. oe drops the cycle after ack unless a new word completes in the same cycle.
- Completing byte with slot full and ack=0: ready=0 for that byte (completing position only). Earlier bytes of the next word still accepted while the slot is full.
- Completing byte with slot full and ack=1 in the same cycle: accepted; new word replaces old; oe stays 1 with no gap.
- ready = !(oe & !ack & (count+1 == effective target)). For count=0 the effective target is the clamped length input.
- ie=1 while ready=0: byte dropped, state unchanged, overrun set. overrun is cleared only by reset.
- abort=1: count=0, partial bytes cleared, next byte treated as a first byte. The output slot is not affected; ie in the same cycle as abort is ignored (no overrun).
- ie=0: no state change besides the ack handling.
- reset mid-word or with oe=1: everything is cleared immediately (asynchronous); the word is lost.

Test Plan:
- BYTES=4, BIG_ENDIAN=1, length=0, bytes 12 34 56 78, ack tied 1 -> oe=1 one cycle after the 4th byte, value=0x12345678, value_len=4.
- BIG_ENDIAN=0, length=3, bytes AA BB CC -> value=0x00CCBBAA, value_len=3; then length=1, byte 5A -> value=0x0000005A, value_len=1.
- length=2, bytes 01 02, ack held 0; then bytes 03 04 -> 03 accepted; ready=0 when 04 is offered; overrun=1; value stays 0x00000102 until ack.
- Slot full, completing byte and ack on the same cycle (length=2: 01 02 then 03 04 with ack coincident on 04) -> 04 accepted; oe stays 1 continuously; value changes to 0x00000304.
- length=4, bytes 11 22, abort pulse, then bytes 33 44 55 66 -> single word 0x33445566; no word containing 11/22.
- Reset low for 1 cycle while oe=1 and count=2 -> oe=0, value=0, overrun=0 immediately; next 4 bytes form a clean word.
